// File: rtl/ldpc_decode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_decode_scheduler
// Description : Sequencer for the LDPC decoder core. It loads LLRs, runs
//               alternating CN/VN sweeps with a syndrome check after each,
//               then streams the hard decisions out.
// Revision    : 1.0 - initial release
// ============================================================================
module ldpc_decode_scheduler #(
  parameter int LOG2N    = 4,
  parameter int N        = 12,
  parameter int M        = 6,
  parameter int LOG2ITER = 5,
  parameter int MAX_ITER = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                llr_wr_en,
  output logic                cn_en,
  output logic                vn_en,
  output logic [LOG2N-1:0]    addr,
  input  logic                syndrome_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          phase,
  output logic [LOG2ITER-1:0] iter_count,
  output logic                converged,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_LOAD = 3'd1,
    PH_CN   = 3'd2,
    PH_VN   = 3'd3,
    PH_CHK  = 3'd4,
    PH_OUT  = 3'd5
  } phase_e;

  localparam logic [LOG2N-1:0]    c_last_n    = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0]    c_last_m    = LOG2N'(M - 1);
  localparam logic [LOG2ITER-1:0] c_last_iter = LOG2ITER'(MAX_ITER - 1);

  phase_e              state_q, state_d;
  logic [LOG2N-1:0]    cnt_q, cnt_d;
  logic [LOG2ITER-1:0] iter_q, iter_d;
  logic                conv_q, conv_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    done_d  = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (start) begin
          state_d = PH_LOAD;
          cnt_d   = '0;
          iter_d  = '0;
          conv_d  = 1'b0;
        end
      end
      PH_LOAD: begin
        if (in_valid) begin
          if (cnt_q == c_last_n) begin
            state_d = PH_CN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end
      PH_CN: begin
        if (cnt_q == c_last_m) begin
          state_d = PH_VN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LOG2N'(1);
        end
      end
      PH_VN: begin
        if (cnt_q == c_last_n) begin
          state_d = PH_CHK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LOG2N'(1);
        end
      end
      PH_CHK: begin
        cnt_d  = '0;
        iter_d = iter_q + LOG2ITER'(1);
        // Convergence wins even on the last permitted iteration.
        if (syndrome_zero) begin
          conv_d  = 1'b1;
          state_d = PH_OUT;
        end else if (iter_q == c_last_iter) begin
          conv_d  = 1'b0;
          state_d = PH_OUT;
        end else begin
          state_d = PH_CN;
        end
      end
      PH_OUT: begin
        if (out_ready) begin
          if (cnt_q == c_last_n) begin
            state_d = PH_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end
      default: state_d = PH_IDLE;
    endcase
    // Abort abandons the codeword but keeps the result registers frozen.
    if (abort && (state_q != PH_IDLE)) begin
      state_d = PH_IDLE;
      cnt_d   = '0;
      iter_d  = iter_q;
      conv_d  = conv_q;
      done_d  = 1'b0;
    end
  end

  assign phase      = state_q;
  assign in_ready   = (state_q == PH_LOAD);
  assign cn_en      = (state_q == PH_CN);
  assign vn_en      = (state_q == PH_VN);
  assign out_valid  = (state_q == PH_OUT);
  assign busy       = (state_q != PH_IDLE);
  assign addr       = (state_q == PH_CHK) ? '0 : cnt_q;
  assign llr_wr_en  = in_valid & in_ready;
  assign iter_count = iter_q;
  assign converged  = conv_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_decode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldpc_decode_scheduler
// Description : Scoreboard bench for ldpc_decode_scheduler; expected address
//               streams and results come from a codeword-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldpc_decode_scheduler;

  localparam int LOG2N    = 4;
  localparam int N        = 12;
  localparam int M        = 6;
  localparam int LOG2ITER = 5;
  localparam int MAX_ITER = 20;

  typedef struct {
    int it;
    int cv;
    int lat;
  } res_t;

  logic                clk = 1'b0;
  logic                rst, start, abort, in_valid, out_ready;
  logic                in_ready, llr_wr_en, cn_en, vn_en, out_valid;
  logic                syndrome_zero, converged, busy, done;
  logic [LOG2N-1:0]    addr;
  logic [2:0]          phase;
  logic [LOG2ITER-1:0] iter_count;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   chk_cnt = 0;
  int   target_chk = -1;
  int   done_cnt = 0;
  int   wr_q[$];
  int   cn_q[$];
  int   vn_q[$];
  int   out_q[$];
  res_t res_q[$];

  ldpc_decode_scheduler #(
    .LOG2N(LOG2N), .N(N), .M(M), .LOG2ITER(LOG2ITER), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .llr_wr_en(llr_wr_en),
    .cn_en(cn_en), .vn_en(vn_en), .addr(addr), .syndrome_zero(syndrome_zero),
    .out_valid(out_valid), .out_ready(out_ready), .phase(phase),
    .iter_count(iter_count), .converged(converged), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Syndrome goes clean in the CHK whose zero-based index equals target_chk.
  assign syndrome_zero = (phase == 3'd4) && (chk_cnt == target_chk);

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    chk_cnt <= (phase == 3'd0) ? 0 : ((phase == 3'd4) ? chk_cnt + 1 : chk_cnt);
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input string name, inout int q[$], input int got);
    chk({name, "_pending"}, int'(q.size() != 0), 1);
    if (q.size() != 0) chk(name, got, q.pop_front());
  endtask

  task automatic monitor();
    res_t r;
    forever begin
      @(negedge clk);
      if (llr_wr_en) pop_cmp("wr_addr", wr_q, int'(addr));
      if (cn_en) pop_cmp("cn_addr", cn_q, int'(addr));
      if (vn_en) pop_cmp("vn_addr", vn_q, int'(addr));
      if (out_valid && out_ready) pop_cmp("out_addr", out_q, int'(addr));
      if (done) begin
        chk("done_expected", int'(res_q.size() != 0), 1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          chk("iter_count", int'(iter_count), r.it);
          chk("converged", int'(converged), r.cv);
          chk("chk_cycles", chk_cnt, r.it);
          chk("done_phase", int'(phase), 0);
          if (r.lat >= 0) chk("latency", cyc - start_cyc, r.lat);
        end
        done_cnt++;
      end
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_phase"}, int'(phase), 0);
    chk({name, "_addr"}, int'(addr), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_en"}, int'({in_ready, cn_en, vn_en, out_valid, done}), 0);
    chk({name, "_iter"}, int'(iter_count), 0);
    chk({name, "_conv"}, int'(converged), 0);
  endtask

  task automatic flush();
    wr_q.delete();
    cn_q.delete();
    vn_q.delete();
    out_q.delete();
  endtask

  // mode: 0 run to completion, 1 abort in first CN sweep, 2 reset mid VN.
  task automatic run_cw(input int tgt, input bit gaps, input bit bp5, input int mode);
    int   it, cv, d0, hold;
    bit   stalled;
    res_t r;
    cv = (tgt >= 0) ? 1 : 0;
    it = (tgt >= 0) ? tgt + 1 : MAX_ITER;
    target_chk = tgt;
    for (int i = 0; i < N; i++) wr_q.push_back(i);
    for (int k = 0; k < it; k++) begin
      for (int i = 0; i < M; i++) cn_q.push_back(i);
      for (int i = 0; i < N; i++) vn_q.push_back(i);
    end
    for (int i = 0; i < N; i++) out_q.push_back(i);
    if (mode == 0) begin
      r.it  = it;
      r.cv  = cv;
      r.lat = (gaps || bp5) ? -1 : 1 + 2 * N + it * (M + N + 1);
      res_q.push_back(r);
    end
    d0 = done_cnt;
    hold = 0;
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (done_cnt != d0) break;
      stalled   = 1'b0;
      in_valid  = gaps ? 1'($urandom % 2) : 1'b1;
      start     = gaps && (phase == 3'd1) && 1'($urandom % 2);
      out_ready = gaps ? ($urandom % 4 != 0) : 1'b1;
      if (bp5 && phase == 3'd5 && addr == 4'd5 && hold < 3) begin
        out_ready = 1'b0;
        hold++;
        stalled = 1'b1;
      end
      if (mode == 1 && phase == 3'd2 && addr == 4'd2) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle("abort");
        flush();
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        return;
      end
      if (mode == 2 && phase == 3'd3 && addr == 4'd4) begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("rst_mid_vn");
        flush();
        return;
      end
      @(posedge clk); #1;
      if (stalled) begin
        chk("bp_addr_held", int'(addr), 5);
        chk("bp_out_valid", int'(out_valid), 1);
      end
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");
    fork
      monitor();
    join_none
    run_cw(0, 1'b0, 1'b0, 0);                // early convergence, 44 cycles
    run_cw(3, 1'b1, 1'b0, 0);                // gapped load, start in LOAD
    run_cw(-1, 1'b0, 1'b0, 0);               // runs to the iteration limit
    run_cw(MAX_ITER - 1, 1'b0, 1'b0, 0);     // converges on last iteration
    run_cw(2, 1'b0, 1'b1, 0);                // output backpressure at addr 5
    run_cw(-1, 1'b0, 1'b0, 1);               // abort in CN
    run_cw(-1, 1'b0, 1'b0, 2);               // reset mid VN
    for (int k = 0; k < 6; k++) begin
      run_cw(int'($urandom_range(0, MAX_ITER)) - 1, 1'($urandom % 2), 1'b0, 0);
    end
    repeat (2) @(posedge clk);
    chk("queues_empty",
        wr_q.size() + cn_q.size() + vn_q.size() + out_q.size() + res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
